// File: rtl/riscky_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional checksum state exists only when LOADER_CHECKSUM_EN is defined.
package riscky_loader_pkg;

  localparam int DEPTH_DEFAULT = 1024;
  localparam int HDR_LEN       = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
`ifdef LOADER_CHECKSUM_EN
    ,
    ST_CHK    = 3'd7
`endif
  } state_t;

  // Word index to word-aligned byte address.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Little-endian byte-to-word packer: the first byte pushed lands in bits 7:0.
// word_full flags the push that completes the current word.
module loader_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (push) begin
      word_q <= word_next;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Count wraps to zero on the fourth byte, so the next word starts clean.
  assign word_next = {din, word_q[31:8]};
  assign word_full = push && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the core in reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader
  import riscky_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   core_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] instr_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t                 state_q, state_d;
  logic [HDR_LEN*8-1:0]   len_q;
  logic [HDR_LEN*8-1:0]   len_hdr;
  logic [CW-1:0]          cnt_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic                   accept;
  logic                   start_ok;
  logic                   last_word;
  logic                   pk_push;
  logic                   pk_full;
  logic [31:0]            pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign len_hdr   = {byte_data, len_q[7:0]};
  assign last_word = ((32'(cnt_q) + 32'd1) == {16'd0, len_q});
  assign pk_push   = (state_q == ST_DATA) && accept;

  loader_word_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .push      (pk_push),
    .din       (byte_data),
    .word_next (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (len_hdr == '0)
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          else if ({16'd0, len_hdr} > 32'(DEPTH))
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: if (pk_full) state_d = ST_WRITE;
      ST_WRITE: begin
        if (last_word)
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        else
          state_d = ST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: if (accept) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok)
        cnt_q <= '0;
      else if (state_q == ST_WRITE)
        cnt_q <= cnt_q + CW'(1);
      if (state_q == ST_LEN_LO && accept)
        len_q[7:0] <= byte_data;
      if (state_q == ST_LEN_HI && accept)
        len_q <= len_hdr;
      // Address and data are latched on the completing byte so they hold after WRITE.
      if (pk_full) begin
        addr_q  <= word_addr(32'(cnt_q));
        wdata_q <= pk_word;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      csum_q <= '0;
    else if (start_ok)
      csum_q <= '0;
    else if (pk_push)
      csum_q <= csum_q ^ byte_data;
  end

  assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign busy       = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_WRITE)  ||
                      (state_q == ST_CHK);
`else
  assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA);
  assign busy       = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_WRITE);
`endif

  assign mem_we      = (state_q == ST_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign core_rst    = (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a per-cycle vector table plus hand-written
// sequences for length errors, empty images, stalls, reset and the checksum option.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] instr_count;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  always @(negedge clk) if (rst && mem_we) wr_cnt++;

  typedef struct {
    logic        st;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic        crst;
    logic [10:0] cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic bv, input logic [7:0] bd);
    @(negedge clk);
    start = st;
    byte_valid = bv;
    byte_data = bd;
    #1;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic bsy, input logic dn, input logic er,
                           input logic crst, input logic [10:0] cnt);
    chk({tag, ".ready"}, 32'(byte_ready), 32'(rdy));
    chk({tag, ".we"},    32'(mem_we),     32'(we));
    chk({tag, ".addr"},  mem_addr,        addr);
    chk({tag, ".wdata"}, mem_wdata,       wd);
    chk({tag, ".busy"},  32'(busy),       32'(bsy));
    chk({tag, ".done"},  32'(done),       32'(dn));
    chk({tag, ".err"},   32'(err),        32'(er));
    chk({tag, ".crst"},  32'(core_rst),   32'(crst));
    chk({tag, ".cnt"},   32'(instr_count), 32'(cnt));
  endtask

  initial begin
    int wr0;

    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
    tbl[8]  = '{1'b0, 1'b1, 8'hB3, 1'b1, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1};
    tbl[9]  = '{1'b0, 1'b1, 8'h82, 1'b1, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1};
    tbl[10] = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4, 32'h002082B3, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, 32'h002082B3, 1'b0, 1'b1, 1'b0, 1'b1, 11'd2};

    repeat (3) @(negedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    rst = 1'b1;

`ifndef LOADER_CHECKSUM_EN
    // Two-word image, one vector per clock.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].st, tbl[i].bv, tbl[i].bd);
      check_all($sformatf("load2.v%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd,
                tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].crst, tbl[i].cnt);
    end
    chk("load2.writes", 32'(wr_cnt), 32'd2);

    // N = 1025 exceeds DEPTH.
    wr0 = wr_cnt;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b0, 8'h00);
    chk("toolong.err",  32'(err),      32'd1);
    chk("toolong.crst", 32'(core_rst), 32'd0);
    chk("toolong.busy", 32'(busy),     32'd0);
    drive(1'b0, 1'b1, 8'h55);
    chk("toolong.hold", 32'(err),      32'd1);
    chk("toolong.nowr", 32'(wr_cnt),   32'(wr0));

    // Empty image finishes straight after the header.
    drive(1'b1, 1'b0, 8'h00);
    chk("empty.errclr", 32'(err), 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("empty.errgone", 32'(err), 32'd0);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("empty.done", 32'(done),        32'd1);
    chk("empty.crst", 32'(core_rst),    32'd1);
    chk("empty.cnt",  32'(instr_count), 32'd0);
    chk("empty.nowr", 32'(wr_cnt),      32'(wr0));

    // Gapped byte stream, and a byte offered during WRITE is refused.
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hBB);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hCC);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hDD);
    drive(1'b0, 1'b1, 8'hEE);
    check_all("stall.write", 1'b0, 1'b1, 32'h0, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    drive(1'b0, 1'b0, 8'h00);
    check_all("stall.done", 1'b0, 1'b0, 32'h0, 32'hDDCCBBAA, 1'b0, 1'b1, 1'b0, 1'b1, 11'd1);

    // Reset mid-word, then a fresh session must not see the stale bytes.
    wr0 = wr_cnt;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b1, 8'hBB);
    drive(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    check_all("midrst", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    drive(1'b0, 1'b1, 8'h33);
    drive(1'b0, 1'b1, 8'h44);
    drive(1'b0, 1'b0, 8'h00);
    check_all("fresh.write", 1'b0, 1'b1, 32'h0, 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    drive(1'b0, 1'b0, 8'h00);
    chk("fresh.done", 32'(done), 32'd1);
    chk("fresh.cnt",  32'(instr_count), 32'd1);
    chk("fresh.wr",   32'(wr_cnt), 32'(wr0 + 1));
`else
    // Checksum: good byte, bad byte, and an empty image.
    for (int k = 0; k < 2; k++) begin
      logic [7:0] cs;
      cs = (k == 0) ? 8'h13 : 8'h12;
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h01);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h13);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      check_all($sformatf("cs%0d.write", k), 1'b0, 1'b1, 32'h0, 32'h00000013,
                1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
      drive(1'b0, 1'b1, cs);
      check_all($sformatf("cs%0d.chk", k), 1'b1, 1'b0, 32'h0, 32'h00000013,
                1'b1, 1'b0, 1'b0, 1'b0, 11'd1);
      drive(1'b0, 1'b0, 8'h00);
      chk($sformatf("cs%0d.done", k), 32'(done), (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cs%0d.err", k),  32'(err),  (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("cs%0d.crst", k), 32'(core_rst), (k == 0) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    chk("cs0len.ready", 32'(byte_ready), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    chk("cs0len.done", 32'(done), 32'd1);
    chk("cs0len.cnt",  32'(instr_count), 32'd0);
    chk("cs.writes",   32'(wr_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
